prediction_feature_rx: RTL and testbench

//   Input stage directly upstream of the prediction core in user_project_wrapper.

---
 rtl/prediction_feature_rx.sv | 270 +++++++++++++++++++++++++++
 tb/tb_prediction_feature_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prediction_feature_rx.sv
// prediction_feature_rx
//   Input stage ahead of the prediction core. Resynchronises a byte-wide
//   strobed feature stream from io_in. Assembles N_FEAT bytes into one vector.
//   Hands the vector to the core through a one-entry valid/ready slot and
//   counts lost frames, saturating at 255.
//   Optional feature macro: FRAME_PARITY_EN adds an even-parity check on
//   io_in[10]. A frame containing a byte with bad parity is discarded.
module prediction_feature_rx #(
    parameter int N_FEAT      = 8,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [37:0]            io_in,
    output logic [37:0]            io_oeb,
    output logic [N_FEAT*DW-1:0]   feat_vec_o,
    output logic                   feat_valid_o,
    input  logic                   feat_ready_i,
    output logic [7:0]             drop_cnt_o,
    output logic                   busy_o
);

    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_FEAT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    // Synchroniser chain and edge detector
    logic [10:0]          sync_r [SYNC_STAGES];
    logic [10:0]          sync_out_s;
    logic                 strb_d_r;
    logic                 event_s;
    logic                 sof_s;
    logic [DW-1:0]        data_s;

    // Frame assembly state
    state_t               state_r;
    state_t               state_nxt_s;
    logic [IW-1:0]        idx_r;
    logic [IW-1:0]        idx_nxt_s;
    logic [TW-1:0]        idle_r;
    logic [TW-1:0]        idle_nxt_s;
    logic [N_FEAT*DW-1:0] asm_r;
    logic [N_FEAT*DW-1:0] asm_nxt_s;
    logic                 store_s;
    logic                 restart_s;
    logic                 reclaim_s;
    logic                 abort_s;
    logic                 complete_s;
    logic [IW-1:0]        lane_s;

    // Output slot and drop bookkeeping
    logic                 slot_free_s;
    logic                 load_s;
    logic                 drop_s;
    logic                 frame_bad_s;
    logic [N_FEAT*DW-1:0] vec_r;
    logic                 valid_r;
    logic [7:0]           drop_r;
    logic                 unused_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign sof_s      = sync_out_s[1];
    assign data_s     = sync_out_s[9:2];
    assign event_s    = sync_out_s[0] & ~strb_d_r;

    // All pads are inputs; the enables never change.
    assign io_oeb       = {38{1'b1}};
    assign feat_vec_o   = vec_r;
    assign feat_valid_o = valid_r;
    assign drop_cnt_o   = drop_r;
    assign busy_o       = (state_r == S_COLLECT);

    // Resynchronise the used part of io_in into the clock domain
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 11'd0;
            end
            strb_d_r <= 1'b0;
        end else begin
            sync_r[0] <= io_in[10:0];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            strb_d_r <= sync_out_s[0];
        end
    end

`ifdef FRAME_PARITY_EN
    logic bad_r;
    logic bad_nxt_s;
    logic par_err_s;

    // Even parity bit over one data byte
    function automatic logic even_parity(input logic [DW-1:0] d);
        return ^d;
    endfunction

    assign unused_s = ^io_in[37:11];

    // Accumulate the per-frame parity error flag; a sof byte starts it afresh
    always_comb begin
        par_err_s = (sync_out_s[10] != even_parity(data_s));
        bad_nxt_s = bad_r;
        if (store_s) begin
            if (restart_s) begin
                bad_nxt_s = par_err_s;
            end else begin
                bad_nxt_s = bad_r | par_err_s;
            end
        end else begin
            bad_nxt_s = bad_r;
        end
        frame_bad_s = bad_nxt_s;
    end

    // Parity error flag register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bad_r <= 1'b0;
        end else begin
            bad_r <= bad_nxt_s;
        end
    end
`else
    assign unused_s    = ^{io_in[37:11], sync_out_s[10]};
    assign frame_bad_s = 1'b0;
`endif

    // Frame FSM: byte placement, restart on sof, idle timeout
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        idle_nxt_s  = idle_r;
        store_s     = 1'b0;
        restart_s   = 1'b0;
        reclaim_s   = 1'b0;
        abort_s     = 1'b0;
        complete_s  = 1'b0;
        lane_s      = '0;
        case (state_r)
            S_IDLE: begin
                idle_nxt_s = '0;
                if (event_s && sof_s) begin
                    store_s   = 1'b1;
                    restart_s = 1'b1;
                    idx_nxt_s = IW'(1);
                    if (N_FEAT == 1) begin
                        complete_s  = 1'b1;
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_COLLECT;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (event_s) begin
                    idle_nxt_s = '0;
                    store_s    = 1'b1;
                    if (sof_s) begin
                        // A new sof wins over a coinciding timeout; one drop.
                        restart_s = 1'b1;
                        reclaim_s = 1'b1;
                        idx_nxt_s = IW'(1);
                        if (N_FEAT == 1) begin
                            complete_s  = 1'b1;
                            state_nxt_s = S_IDLE;
                        end else begin
                            state_nxt_s = S_COLLECT;
                        end
                    end else begin
                        lane_s = idx_r;
                        if (idx_r == IDX_LAST) begin
                            complete_s  = 1'b1;
                            state_nxt_s = S_IDLE;
                        end else begin
                            idx_nxt_s = idx_r + IW'(1);
                        end
                    end
                end else if (idle_r == TO_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    idle_nxt_s = idle_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Write the incoming byte into its lane of the assembly buffer
    always_comb begin
        asm_nxt_s = asm_r;
        if (store_s) begin
            asm_nxt_s[lane_s*DW +: DW] = data_s;
        end else begin
            asm_nxt_s = asm_r;
        end
    end

    // Decide whether a completed frame loads the output slot or is dropped
    always_comb begin
        slot_free_s = ~valid_r | feat_ready_i;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        if (complete_s) begin
            if (frame_bad_s) begin
                drop_s = 1'b1;
            end else if (slot_free_s) begin
                load_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (reclaim_s || abort_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // FSM state, lane index, idle counter and assembly buffer
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            idle_r  <= '0;
            asm_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            idle_r  <= idle_nxt_s;
            asm_r   <= asm_nxt_s;
        end
    end

    // Output slot: load a completed frame, clear valid after a transfer
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vec_r   <= '0;
            valid_r <= 1'b0;
        end else if (load_s) begin
            vec_r   <= asm_nxt_s;
            valid_r <= 1'b1;
        end else if (valid_r && feat_ready_i) begin
            valid_r <= 1'b0;
        end
    end

    // Saturating dropped-frame counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            drop_r <= 8'd0;
        end else if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

endmodule

// File: tb/tb_prediction_feature_rx.sv
// Self-checking bench for prediction_feature_rx (default parameters).
// A queue-based frame model predicts delivered vectors and the drop count.
module tb_prediction_feature_rx;

    localparam int N_FEAT  = 8;
    localparam int TIMEOUT = 1024;
`ifdef FRAME_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [37:0] io_in;
    logic [37:0] io_oeb;
    logic [63:0] feat_vec;
    logic        feat_valid;
    logic        feat_ready;
    logic [7:0]  drop_cnt;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prediction_feature_rx dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .io_in        (io_in),
        .io_oeb       (io_oeb),
        .feat_vec_o   (feat_vec),
        .feat_valid_o (feat_valid),
        .feat_ready_i (feat_ready),
        .drop_cnt_o   (drop_cnt),
        .busy_o       (busy)
    );

    // Observed transfers: valid&ready seen half a cycle before the edge
    logic [63:0] got_q[$];
    always @(negedge clk) begin
        if (rst_n && feat_valid && feat_ready) got_q.push_back(feat_vec);
    end

    // Reference model state
    bit          in_frame;
    bit          fbad;
    logic [7:0]  fq[$];
    bit          m_ready;
    bit          m_valid;
    logic [63:0] m_vec;
    int          m_drops;
    logic [63:0] exp_q[$];

    function automatic logic [7:0] exp_drop();
        return (m_drops > 255) ? 8'd255 : 8'(m_drops);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_byte(input logic [7:0] d, input bit sof, input bit bad);
        logic [63:0] v;
        if (sof) begin
            if (in_frame) m_drops++;
            fq.delete();
            in_frame = 1'b1;
            fbad = bad;
            fq.push_back(d);
        end else if (in_frame) begin
            fq.push_back(d);
            fbad = fbad | bad;
        end
        if (in_frame && fq.size() == N_FEAT) begin
            in_frame = 1'b0;
            v = '0;
            for (int i = 0; i < N_FEAT; i++) v[i*8 +: 8] = fq[i];
            if (PAR_EN && fbad) m_drops++;
            else if (m_valid && !m_ready) m_drops++;
            else if (m_ready) exp_q.push_back(v);
            else begin
                m_valid = 1'b1;
                m_vec = v;
            end
        end
    endtask

    task automatic model_timeout();
        if (in_frame) m_drops++;
        in_frame = 1'b0;
    endtask

    task automatic set_ready(input bit r);
        feat_ready = r;
        m_ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_vec);
            m_valid = 1'b0;
        end
    endtask

    // One byte: data settles, strobe high three cycles, low one cycle
    task automatic send_byte(input logic [7:0] d, input bit sof, input bit badpar, input bit chk_lat);
        io_in[9:2] = d;
        io_in[1]   = sof;
        io_in[10]  = (^d) ^ badpar;
        io_in[0]   = 1'b0;
        tick();
        io_in[0] = 1'b1;
        tick();
        tick();
        if (chk_lat) check("latency_before", 64'(feat_valid), 64'd0);
        tick();
        if (chk_lat) check("latency_at", 64'(feat_valid), 64'd1);
        io_in[0] = 1'b0;
        tick();
        model_byte(d, sof, badpar);
    endtask

    task automatic send_frame(input logic [63:0] v, input int n, input bit lat, input int badidx);
        for (int i = 0; i < n; i++) begin
            send_byte(v[i*8 +: 8], (i == 0), (i == badidx), lat && (i == n - 1));
        end
    endtask

    task automatic cmp_transfers(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_vec"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [63:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] va;
        logic [63:0] vb;
        int          nb;

        io_in = 38'd0;
        feat_ready = 1'b0;
        rst_n = 1'b0;
        in_frame = 1'b0; fbad = 1'b0; m_ready = 1'b0; m_valid = 1'b0; m_vec = '0; m_drops = 0;
        tick_n(3);
        check("rst_vec", feat_vec, 64'd0);
        check("rst_valid", 64'(feat_valid), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        rst_n = 1'b1;
        tick_n(2);

        // 1: basic frame with ready high
        set_ready(1'b1);
        send_frame(64'h0807060504030201, 8, 1'b0, -1);
        tick_n(2);
        check("t1_valid_after", 64'(feat_valid), 64'd0);
        check("t1_drop", 64'(drop_cnt), 64'(exp_drop()));
        check("t1_gotvec", (got_q.size() > 0) ? got_q[0] : 64'd0, 64'h0807060504030201);
        cmp_transfers("t1");

        // 2: slot held while ready low, second frame dropped
        set_ready(1'b0);
        va = rand_vec();
        vb = rand_vec();
        send_frame(va, 8, 1'b1, -1);
        check("t2_valid_a", 64'(feat_valid), 64'd1);
        check("t2_vec_a", feat_vec, va);
        send_frame(vb, 8, 1'b0, -1);
        check("t2_valid_hold", 64'(feat_valid), 64'd1);
        check("t2_vec_hold", feat_vec, va);
        check("t2_drop", 64'(drop_cnt), 64'(exp_drop()));
        set_ready(1'b1);
        tick();
        check("t2_valid_clear", 64'(feat_valid), 64'd0);
        cmp_transfers("t2");

        // 3: partial frame aborted by the idle timeout, exact boundary
        send_frame(rand_vec(), 4, 1'b0, -1);
        check("t3_busy", 64'(busy), 64'd1);
        tick_n(TIMEOUT - 2);
        check("t3_busy_before_to", 64'(busy), 64'd1);
        tick();
        model_timeout();
        check("t3_busy_after_to", 64'(busy), 64'd0);
        check("t3_drop", 64'(drop_cnt), 64'(exp_drop()));
        check("t3_valid", 64'(feat_valid), 64'd0);
        send_frame(rand_vec(), 8, 1'b1, -1);
        tick_n(2);
        cmp_transfers("t3");

        // 4: sof restart mid-frame
        send_frame(rand_vec(), 6, 1'b0, -1);
        vb = rand_vec();
        send_frame(vb, 8, 1'b0, -1);
        tick_n(2);
        check("t4_drop", 64'(drop_cnt), 64'(exp_drop()));
        cmp_transfers("t4");

        // 5: asynchronous reset mid-frame while valid is high
        set_ready(1'b0);
        send_frame(rand_vec(), 8, 1'b0, -1);
        send_frame(rand_vec(), 3, 1'b0, -1);
        check("t5_valid_pre", 64'(feat_valid), 64'd1);
        check("t5_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #2;
        check("t5_vec", feat_vec, 64'd0);
        check("t5_valid", 64'(feat_valid), 64'd0);
        check("t5_drop", 64'(drop_cnt), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        cmp_transfers("t5_pre");
        in_frame = 1'b0; m_valid = 1'b0; m_drops = 0;
        io_in = 38'd0;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(2);
        set_ready(1'b1);
        send_frame(rand_vec(), 8, 1'b1, -1);
        tick_n(2);
        check("t5_drop_post", 64'(drop_cnt), 64'd0);
        cmp_transfers("t5_post");

        // Randomized frames: random length, stray sof, random ready
        for (int it = 0; it < 24; it++) begin
            set_ready(1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 11);
            for (int b = 0; b < nb; b++) begin
                send_byte(8'($urandom), (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0),
                          1'b0, 1'b0);
            end
            tick();
            check("rnd_valid", 64'(feat_valid), 64'(m_valid));
            if (m_valid) check("rnd_vec", feat_vec, m_vec);
            check("rnd_drop", 64'(drop_cnt), 64'(exp_drop()));
        end
        set_ready(1'b1);
        tick_n(TIMEOUT + 4);
        model_timeout();
        check("rnd_busy_end", 64'(busy), 64'd0);
        check("rnd_drop_end", 64'(drop_cnt), 64'(exp_drop()));
        cmp_transfers("rnd");

`ifdef FRAME_PARITY_EN
        // Parity: one bad byte discards the whole frame
        send_frame(rand_vec(), 8, 1'b0, 3);
        tick_n(2);
        check("par_valid", 64'(feat_valid), 64'd0);
        check("par_drop", 64'(drop_cnt), 64'(exp_drop()));
        send_frame(rand_vec(), 8, 1'b0, -1);
        tick_n(2);
        cmp_transfers("par");
`endif

        // Saturation: a run of sof bytes drops every restarted frame
        for (int i = 0; i < 300; i++) begin
            send_byte(8'($urandom), 1'b1, 1'b0, 1'b0);
            if (i == 10) check("sat_mid", 64'(drop_cnt), 64'(exp_drop()));
        end
        check("sat_drop", 64'(drop_cnt), 64'd255);
        tick_n(TIMEOUT + 4);
        model_timeout();
        check("sat_hold", 64'(drop_cnt), 64'd255);
        check("sat_busy", 64'(busy), 64'd0);
        cmp_transfers("sat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
